// File: rtl/back_end_native.sv
// Cache back-end: drains the write-through buffer word by word and fills lines with
// back-to-back word reads; at most one memory access outstanding, writes take priority.
module back_end_native #(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int LINE2MEM_W = 2,
    localparam int FE_BYTES_W = $clog2(FE_DATA_W/8)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      write_valid,
    input  logic [FE_ADDR_W-FE_BYTES_W-1:0]           write_addr,
    input  logic [FE_DATA_W-1:0]                      write_wdata,
    input  logic [FE_DATA_W/8-1:0]                    write_wstrb,
    output logic                                      write_ready,
    input  logic                                      replace_valid,
    input  logic [FE_ADDR_W-FE_BYTES_W-LINE2MEM_W-1:0] replace_addr,
    output logic                                      replace,
    output logic                                      read_valid,
    output logic [LINE2MEM_W-1:0]                     read_addr,
    output logic [FE_DATA_W-1:0]                      read_rdata,
    output logic                                      mem_valid,
    output logic [FE_ADDR_W-1:0]                      mem_addr,
    output logic [FE_DATA_W-1:0]                      mem_wdata,
    output logic [FE_DATA_W/8-1:0]                    mem_wstrb,
    input  logic [FE_DATA_W-1:0]                      mem_rdata,
    input  logic                                      mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_READ     = 2'd2,
        S_READ_END = 2'd3
    } state_t;

    localparam logic [LINE2MEM_W-1:0] CNT_ONE  = LINE2MEM_W'(1);
    localparam logic [LINE2MEM_W-1:0] CNT_LAST = {LINE2MEM_W{1'b1}};

    state_t                                      state_q, state_d;
    logic [LINE2MEM_W-1:0]                       cnt_q, cnt_d;
    logic [FE_ADDR_W-FE_BYTES_W-1:0]             waddr_q, waddr_d;
    logic [FE_DATA_W-1:0]                        wdata_q, wdata_d;
    logic [FE_DATA_W/8-1:0]                      wstrb_q, wstrb_d;
    logic [FE_ADDR_W-FE_BYTES_W-LINE2MEM_W-1:0]  laddr_q, laddr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            laddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            laddr_q <= laddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        laddr_d = laddr_q;
        case (state_q)
            S_IDLE: begin
                if (write_valid) begin
                    state_d = S_WRITE;
                    waddr_d = write_addr;
                    wdata_d = write_wdata;
                    wstrb_d = write_wstrb;
                end else if (replace_valid) begin
                    state_d = S_READ;
                    laddr_d = replace_addr;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                if (mem_ready) state_d = S_IDLE;
            end
            S_READ: begin
                if (mem_ready) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_d = S_READ_END;
                end
            end
            // One dead cycle so the cache can drop replace_valid before IDLE re-samples it.
            S_READ_END: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        write_ready = 1'b0;
        replace     = 1'b0;
        read_valid  = 1'b0;
        read_addr   = '0;
        read_rdata  = '0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        case (state_q)
            S_WRITE: begin
                mem_valid   = 1'b1;
                mem_addr    = {waddr_q, {FE_BYTES_W{1'b0}}};
                mem_wdata   = wdata_q;
                mem_wstrb   = wstrb_q;
                write_ready = mem_ready;
            end
            S_READ: begin
                replace    = 1'b1;
                mem_valid  = 1'b1;
                mem_addr   = {laddr_q, cnt_q, {FE_BYTES_W{1'b0}}};
                read_valid = mem_ready;
                if (mem_ready) begin
                    read_addr  = cnt_q;
                    read_rdata = mem_rdata;
                end
            end
            S_READ_END: replace = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_back_end_native.sv
// Directed bench for back_end_native: a transaction-level model predicts every output
// each cycle, and hand-computed literals pin the main scenarios.
module tb_back_end_native;

    logic        clk, reset;
    logic        write_valid;
    logic [29:0] write_addr;
    logic [31:0] write_wdata;
    logic [3:0]  write_wstrb;
    logic        write_ready;
    logic        replace_valid;
    logic [27:0] replace_addr;
    logic        replace, read_valid;
    logic [1:0]  read_addr;
    logic [31:0] read_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    back_end_native dut (
        .clk(clk), .reset(reset),
        .write_valid(write_valid), .write_addr(write_addr), .write_wdata(write_wdata),
        .write_wstrb(write_wstrb), .write_ready(write_ready),
        .replace_valid(replace_valid), .replace_addr(replace_addr), .replace(replace),
        .read_valid(read_valid), .read_addr(read_addr), .read_rdata(read_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    wr_t         wbuf[$];
    logic [31:0] memarr[logic [31:0]];
    int          checks = 0, errors = 0, cyc = 0;

    // Memory responder state
    int wait_n = 0, mcnt = 0, done_ack = 0, n_popped = 0;

    // Observation logs
    int          n_done = 0, n_wr_done = 0, n_replace = 0, n_fill = 0, n_tail = 0, cur_wait = 0;
    logic        prev_rep = 1'b0;
    logic [31:0] wr_addr_log[$], rv_addr_log[$], rv_dat_log[$];
    int          wait_log[$], rv_idx_log[$], rv_cyc_log[$], ev_log[$];

    // Transaction-level model: the access on the bus now, plus the post-fill dead cycle
    logic        m_act = 1'b0, m_wr = 1'b0, m_tail = 1'b0;
    logic [31:0] m_waddr = '0, m_data = '0, m_line = '0, m_beat = '0;
    logic [3:0]  m_strb = '0;

    function automatic logic [31:0] memread(input logic [31:0] a);
        if (memarr.exists(a)) return memarr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        logic        e_rv, e_wrdy, e_rep;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_ws;
        cyc++;
        if (reset) begin
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wstrb", mem_wstrb, 0);
            chk("rst_write_ready", write_ready, 0);
            chk("rst_read_valid", read_valid, 0);
            chk("rst_replace", replace, 0);
            chk("rst_read_addr", read_addr, 0);
            chk("rst_read_rdata", read_rdata, 0);
            m_act = 1'b0; m_tail = 1'b0; prev_rep = 1'b0; cur_wait = 0;
            return;
        end
        e_addr = !m_act ? 32'h0 : m_wr ? m_waddr * 4 : m_line * 16 + m_beat * 4;
        e_wd   = (m_act && m_wr) ? m_data : 32'h0;
        e_ws   = (m_act && m_wr) ? m_strb : 4'h0;
        e_wrdy = m_act && m_wr && mem_ready;
        e_rv   = m_act && !m_wr && mem_ready;
        e_rep  = (m_act && !m_wr) || m_tail;
        chk("mem_valid", mem_valid, m_act);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_wstrb", mem_wstrb, e_ws);
        chk("write_ready", write_ready, e_wrdy);
        chk("read_valid", read_valid, e_rv);
        chk("replace", replace, e_rep);
        if (e_rv) begin
            chk("read_addr", read_addr, m_beat);
            chk("read_rdata", read_rdata, memread(e_addr));
        end

        if (mem_valid && !mem_ready) cur_wait++;
        if (write_ready) begin
            wr_addr_log.push_back(mem_addr); wait_log.push_back(cur_wait);
            ev_log.push_back(1); n_wr_done++;
        end
        if (read_valid) begin
            rv_addr_log.push_back(mem_addr); rv_idx_log.push_back(int'(read_addr));
            rv_dat_log.push_back(read_rdata); rv_cyc_log.push_back(cyc); ev_log.push_back(2);
        end
        if (mem_valid && mem_ready) begin n_done++; cur_wait = 0; end
        if (replace) n_replace++;
        if (replace && !prev_rep) n_fill++;
        if (replace && !mem_valid) n_tail++;
        prev_rep = replace;

        if (m_tail) m_tail = 1'b0;
        else if (m_act) begin
            if (mem_ready) begin
                if (m_wr) m_act = 1'b0;
                else if (m_beat == 3) begin m_act = 1'b0; m_tail = 1'b1; end
                else m_beat = m_beat + 1;
            end
        end else if (write_valid) begin
            m_act = 1'b1; m_wr = 1'b1; m_waddr = 32'(write_addr);
            m_data = write_wdata; m_strb = write_wstrb;
        end else if (replace_valid) begin
            m_act = 1'b1; m_wr = 1'b0; m_line = 32'(replace_addr); m_beat = 0;
        end
    endtask

    task automatic drive_buf();
        write_valid = (wbuf.size() != 0);
        write_addr  = write_valid ? wbuf[0].a : 30'h0;
        write_wdata = write_valid ? wbuf[0].d : 32'h0;
        write_wstrb = write_valid ? wbuf[0].s : 4'h0;
    endtask

    task automatic set_wait(input int n);
        wait_n = n; mcnt = n;
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
        while (n_popped < n_wr_done) begin
            if (wbuf.size() != 0) wbuf.delete(0);
            n_popped++;
        end
        drive_buf();
        if (done_ack != n_done) begin mcnt = wait_n; done_ack = n_done; end
        if (mem_valid && mcnt == 0) mem_ready = 1'b1;
        else begin
            mem_ready = 1'b0;
            if (mem_valid) mcnt--;
        end
        mem_rdata = mem_ready ? memread(mem_addr) : (32'hBAD0_0000 | 32'(cyc));
    endtask

    task automatic wait_tail(input string nm, input int t0);
        int k = 0;
        while (n_tail == t0 && k < 200) begin tick(); k++; end
        chk(nm, 32'(n_tail > t0), 1);
    endtask

    task automatic wait_wr(input string nm, input int base);
        int k = 0;
        while (wr_addr_log.size() == base && k < 200) begin tick(); k++; end
        chk(nm, 32'(wr_addr_log.size() > base), 1);
    endtask

    int b, e, f0, r0, t0;
    logic pushed;

    initial begin
        memarr[32'h1000_0000] = 32'h11;
        memarr[32'h1000_0004] = 32'h22;
        memarr[32'h1000_0008] = 32'h33;
        memarr[32'h1000_000C] = 32'h44;
        reset = 1'b1; replace_valid = 1'b0; replace_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        drive_buf(); set_wait(0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Single write, three wait states
        set_wait(3); b = wr_addr_log.size();
        wbuf.push_back('{30'h0000_0400, 32'hDEAD_BEEF, 4'hF}); drive_buf();
        wait_wr("t17_timeout", b);
        if (wr_addr_log.size() > b) begin
            chk("t17_addr", wr_addr_log[b], 32'h0000_1000);
            chk("t17_waits", wait_log[b], 3);
        end
        repeat (2) tick();
        chk("t17_one_pop", wr_addr_log.size() - b, 1);

        // Line fill, ready every cycle; replace_valid held through the dead cycle
        set_wait(0); b = rv_addr_log.size(); f0 = n_fill; r0 = n_replace; t0 = n_tail;
        replace_addr = 28'h100_0000; replace_valid = 1'b1;
        wait_tail("t18_timeout", t0);
        replace_valid = 1'b0;
        repeat (4) tick();
        chk("t18_beats", rv_addr_log.size() - b, 4);
        if (rv_addr_log.size() - b == 4) begin
            chk("t18_a0", rv_addr_log[b], 32'h1000_0000);
            chk("t18_a1", rv_addr_log[b+1], 32'h1000_0004);
            chk("t18_a2", rv_addr_log[b+2], 32'h1000_0008);
            chk("t18_a3", rv_addr_log[b+3], 32'h1000_000C);
            chk("t18_d0", rv_dat_log[b], 32'h11);
            chk("t18_d3", rv_dat_log[b+3], 32'h44);
            chk("t18_i3", rv_idx_log[b+3], 3);
            chk("t18_consecutive", rv_cyc_log[b+3] - rv_cyc_log[b], 3);
        end
        chk("t18_replace_cycles", n_replace - r0, 5);
        chk("t22_single_fill", n_fill - f0, 1);

        // Two buffered writes and a fill request at once: writes first
        set_wait(1); e = ev_log.size(); b = wr_addr_log.size(); t0 = n_tail;
        wbuf.push_back('{30'h0000_0010, 32'h0000_00A1, 4'h3});
        wbuf.push_back('{30'h0000_0011, 32'h0000_00B2, 4'hC}); drive_buf();
        replace_addr = 28'h000_0ABC; replace_valid = 1'b1;
        wait_tail("t19_timeout", t0);
        replace_valid = 1'b0;
        repeat (2) tick();
        if (ev_log.size() - e >= 3) begin
            chk("t19_ev0", ev_log[e], 1);
            chk("t19_ev1", ev_log[e+1], 1);
            chk("t19_ev2", ev_log[e+2], 2);
            chk("t19_wa1", wr_addr_log[b+1], 32'h0000_0044);
        end else chk("t19_events", ev_log.size() - e, 6);

        // Five wait states per beat, write arrives mid-fill and must wait
        set_wait(5); b = rv_addr_log.size(); e = ev_log.size(); r0 = n_replace; t0 = n_tail;
        replace_addr = 28'h000_0200; replace_valid = 1'b1; pushed = 1'b0;
        for (int k = 0; k < 200 && n_tail == t0; k++) begin
            tick();
            if (!pushed && rv_addr_log.size() - b == 1) begin
                wbuf.push_back('{30'h0000_0123, 32'h5555_AAAA, 4'hF}); drive_buf();
                pushed = 1'b1;
            end
        end
        chk("t20_timeout", 32'(n_tail > t0), 1);
        replace_valid = 1'b0;
        wait_wr("t14_write_timeout", wr_addr_log.size() - (n_popped < n_wr_done ? 1 : 0));
        repeat (2) tick();
        chk("t20_replace_cycles", n_replace - r0, 25);
        if (rv_cyc_log.size() - b == 4) begin
            chk("t20_spacing", rv_cyc_log[b+1] - rv_cyc_log[b], 6);
            chk("t20_span", rv_cyc_log[b+3] - rv_cyc_log[b], 18);
        end else chk("t20_beats", rv_cyc_log.size() - b, 4);
        if (ev_log.size() - e == 5) begin
            chk("t14_ev3_read", ev_log[e+3], 2);
            chk("t14_ev4_write", ev_log[e+4], 1);
            chk("t14_waddr", wr_addr_log[wr_addr_log.size()-1], 32'h0000_048C);
        end else chk("t14_events", ev_log.size() - e, 5);

        // Reset during the third beat; fill restarts from word 0
        set_wait(2); b = rv_addr_log.size();
        replace_addr = 28'h000_0300; replace_valid = 1'b1;
        for (int k = 0; k < 100 && rv_addr_log.size() - b < 2; k++) tick();
        chk("t21_two_beats", rv_addr_log.size() - b, 2);
        reset = 1'b1;
        #1;
        chk("t21_rst_valid", mem_valid, 0);
        chk("t21_rst_addr", mem_addr, 0);
        chk("t21_rst_replace", replace, 0);
        repeat (2) tick();
        reset = 1'b0; set_wait(2); b = rv_addr_log.size(); t0 = n_tail;
        wait_tail("t21_timeout", t0);
        replace_valid = 1'b0;
        repeat (3) tick();
        if (rv_addr_log.size() - b == 4) begin
            chk("t21_restart_idx", rv_idx_log[b], 0);
            chk("t21_restart_addr", rv_addr_log[b], 32'h0000_3000);
            chk("t21_last_addr", rv_addr_log[b+3], 32'h0000_300C);
        end else chk("t21_beats", rv_addr_log.size() - b, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
